// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial wide adder sequencer driving an external fulladd4
// Optional signed-overflow output enabled by macro NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 c_in,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 c_out,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   output logic                 ovf,
`endif
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_sum,
   input  logic                 add_cout
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
   logic            carry;
   logic [IW-1:0]   idx;
   logic [W-1:0]    result;
   logic [W-1:0]    result_nxt;
   logic            last;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic            a_msb;
   logic            b_msb;
`endif

   assign add_a   = a_sh[3:0];
   assign add_b   = b_sh[3:0];
   assign add_cin = carry;
   assign last    = (idx == IW'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Result including the nibble being produced this cycle, so the completion edge sees all of it.
   always_comb begin
      result_nxt = result;
      result_nxt[{idx, 2'b00} +: 4] = add_sum;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         result <= '0;
         sum    <= '0;
         c_out  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else if (state == IDLE) begin
         if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= c_in;
            idx    <= '0;
            result <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            a_msb  <= a[W-1];
            b_msb  <= b[W-1];
`endif
         end
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 4;
         b_sh   <= b_sh >> 4;
         carry  <= add_cout;
         idx    <= idx + 1'b1;
         result <= result_nxt;
         if (last) begin
            sum   <= result_nxt;
            c_out <= add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf   <= (a_msb == b_msb) && (result_nxt[W-1] != a_msb);
`endif
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder with a behavioural fulladd4
module tb_nibble_serial_adder;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_sum;
   logic         add_cout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // fulladd4 stand-in
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .c_out    (c_out),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      .ovf      (ovf),
`endif
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
   assign ovf = 1'b0;
`endif

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Issue one operation and wait for done; reports latency and busy cycles.
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output int lat, output int bc);
      a     = xa;
      b     = xb;
      c_in  = xc;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      c_in  = 1'($urandom);
      lat   = 0;
      bc    = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) bc++;
      end
      if (lat >= 40) check("done_timeout", 64'(lat), 64'(NIBBLES));
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lat;
      int bc;
      int pulses;
      logic [W:0]   ref_full;
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      longint       ssum;
      logic         ref_ovf;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};

      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      c_in  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_sum", 64'(sum), 64'd0);
      check("reset_cout", 64'(c_out), 64'd0);
      check("reset_add", 64'({add_a, add_b, add_cin}), 64'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check("reset_ovf", 64'(ovf), 64'd0);
`endif
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc);
         check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].s));
         check($sformatf("vec%0d_cout", i), 64'(c_out), 64'(vecs[i].co));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NIBBLES));
         check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(NIBBLES));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ov));
`endif
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
         check($sformatf("vec%0d_sum_hold", i), 64'(sum), 64'(vecs[i].s));
      end

      // start re-asserted mid-RUN must be ignored
      a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 1) begin
            a = 16'h0F0F; b = 16'h0F0F; start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            pulses++;
            check("ignore_sum", 64'(sum), 64'h5555);
            check("ignore_cout", 64'(c_out), 64'd0);
         end
      end
      check("ignore_done_pulses", 64'(pulses), 64'd1);
      check("ignore_sum_hold", 64'(sum), 64'h5555);

      // reset on the 3rd RUN cycle aborts
      a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_sum", 64'(sum), 64'd0);
      check("abort_cout", 64'(c_out), 64'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("abort_no_done", 64'(pulses), 64'd0);
      run_op(16'h0F0F, 16'h0101, 1'b1, lat, bc);
      check("after_abort_sum", 64'(sum), 64'h1011);
      check("after_abort_latency", 64'(lat), 64'(NIBBLES));
      @(posedge clk);
      #1;

      // randomized against integer arithmetic
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
         ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         sa = ra;
         sb = rb;
         ssum = longint'(sa) + longint'(sb) + longint'(rc);
         ref_ovf = (ssum > ((64'sd1 <<< (W - 1)) - 1)) || (ssum < -(64'sd1 <<< (W - 1)));
         run_op(ra, rb, rc, lat, bc);
         check($sformatf("rand%0d_sum", i), 64'(sum), 64'(ref_full[W-1:0]));
         check($sformatf("rand%0d_cout", i), 64'(c_out), 64'(ref_full[W]));
         check($sformatf("rand%0d_latency", i), 64'(lat), 64'(NIBBLES));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         check($sformatf("rand%0d_ovf", i), 64'(ovf), 64'(ref_ovf));
`endif
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
